// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction class codes, condition codes and field
// bit positions, common to the instruction encoder and decoder.
package isa_pkg;

    typedef enum logic [2:0] {
        CLS_DP_REG = 3'b000,
        CLS_DP_IMM = 3'b001,
        CLS_LS_IMM = 3'b010,
        CLS_LS_REG = 3'b011,
        CLS_BRANCH = 3'b101
    } cls_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int COND_LSB   = 28;
    localparam int CLS_LSB    = 25;
    localparam int P_BIT      = 24;
    localparam int LINK_BIT   = 24;
    localparam int U_BIT      = 23;
    localparam int OPC_LSB    = 21;
    localparam int S_BIT      = 20;
    localparam int L_BIT      = 20;
    localparam int RN_LSB     = 16;
    localparam int RD_LSB     = 12;
    localparam int RS_LSB     = 8;
    localparam int ROT_LSB    = 8;
    localparam int AMT_LSB    = 7;
    localparam int SHIFT_LSB  = 5;
    localparam int REG_SH_BIT = 4;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        set_flags;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [1:0]  shift;
        logic [4:0]  shift_amount;
        logic        use_rs;
        logic [3:0]  rotate_imm;
        logic [7:0]  imm8;
        logic [11:0] imm12;
        logic        load;
        logic [23:0] offset24;
        logic        link;
    } fields_t;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry, 32-bit instruction word FIFO with registered head and occupancy.
module instr_fifo2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem_r [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        push_ok_s;
    logic        pop_ok_s;

    // Never overfill or underflow, whatever the caller does.
    assign push_ok_s = push && (count_r != 2'd2);
    assign pop_ok_s  = pop && (count_r != 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 32-bit words, rejects illegal classes
// and conditions, and streams words out through a two-entry FIFO.
module instr_encoder
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cls,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        set_flags,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [1:0]  shift,
    input  logic [4:0]  shift_amount,
    input  logic        use_rs,
    input  logic [3:0]  rotate_imm,
    input  logic [7:0]  imm8,
    input  logic [11:0] imm12,
    input  logic        load,
    input  logic [23:0] offset24,
    input  logic        link,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [15:0] word_count
);

    function automatic logic [31:0] enc_dp_reg(input fields_t f);
        logic [11:0] low12;
        if (f.use_rs) begin
            low12 = {f.rs, 1'b0, f.shift, 1'b1, f.rm};
        end else begin
            low12 = {f.shift_amount, f.shift, 1'b0, f.rm};
        end
        return {f.cond, 3'b000, f.opcode, f.set_flags, f.rn, f.rd, low12};
    endfunction

    function automatic logic [31:0] enc_dp_imm(input fields_t f);
        return {f.cond, 3'b001, f.opcode, f.set_flags, f.rn, f.rd, f.rotate_imm, f.imm8};
    endfunction

    // Pre-indexed, up, word, no writeback.
    function automatic logic [31:0] enc_ls_imm(input fields_t f);
        return {f.cond, 3'b010, 4'b1100, f.load, f.rn, f.rd, f.imm12};
    endfunction

    function automatic logic [31:0] enc_ls_reg(input fields_t f);
        return {f.cond, 3'b011, 4'b1100, f.load, f.rn, f.rd,
                f.shift_amount, f.shift, 1'b0, f.rm};
    endfunction

    function automatic logic [31:0] enc_branch(input fields_t f);
        return {f.cond, 3'b101, f.link, f.offset24};
    endfunction

    fields_t     fields_s;
    logic [31:0] word_s;
    logic        legal_s;
    logic [1:0]  occ_s;
    logic [31:0] head_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        err_r;
    logic [15:0] word_count_r;

    assign fields_s = '{cond: cond, opcode: opcode, set_flags: set_flags, rd: rd,
                        rn: rn, rm: rm, rs: rs, shift: shift,
                        shift_amount: shift_amount, use_rs: use_rs,
                        rotate_imm: rotate_imm, imm8: imm8, imm12: imm12,
                        load: load, offset24: offset24, link: link};

    // Class-selected encoding and legality of the offered bundle.
    always_comb begin
        word_s  = 32'h0000_0000;
        legal_s = 1'b0;
        case (cls_e'(cls))
            CLS_DP_REG: begin word_s = enc_dp_reg(fields_s); legal_s = 1'b1; end
            CLS_DP_IMM: begin word_s = enc_dp_imm(fields_s); legal_s = 1'b1; end
            CLS_LS_IMM: begin word_s = enc_ls_imm(fields_s); legal_s = 1'b1; end
            CLS_LS_REG: begin word_s = enc_ls_reg(fields_s); legal_s = 1'b1; end
            CLS_BRANCH: begin word_s = enc_branch(fields_s); legal_s = 1'b1; end
            default:    begin word_s = 32'h0000_0000; legal_s = 1'b0; end
        endcase
        if (cond_e'(cond) == COND_NV) begin
            legal_s = 1'b0;
        end else begin
            legal_s = legal_s;
        end
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (occ_s != 2'd2);
    assign out_valid = (occ_s != 2'd0);
    assign out_instr = head_s;
    assign accept_s  = in_valid && in_ready;
    assign push_s    = accept_s && legal_s;
    assign pop_s     = out_valid && out_ready;

    instr_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (occ_s)
    );

    // Rejection pulse and delivered-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r        <= 1'b0;
            word_count_r <= 16'h0000;
        end else begin
            err_r <= accept_s && !legal_s;
            if (pop_s) begin
                word_count_r <= word_count_r + 16'h0001;
            end
        end
    end

    assign err        = err_r;
    assign word_count = word_count_r;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid in 1 / in_ready out 1, field-bundle handshake; transfer when both high at clk edge.
REQ-004 SHALL have ports: cls in 3 instruction class (000 DP_REG, 001 DP_IMM, 010 LS_IMM, 011 LS_REG, 101 BRANCH); cond in 4; opcode in 4; set_flags in 1.
REQ-005 SHALL have ports: rd, rn, rm, rs in 4 each; shift in 2; shift_amount in 5; use_rs in 1.
REQ-006 SHALL have ports: rotate_imm in 4; imm8 in 8; imm12 in 12; load in 1; offset24 in 24; link in 1.
REQ-007 SHALL have ports: out_valid out 1 / out_ready in 1, instruction-word handshake; out_instr out 32 encoded word.
REQ-008 SHALL have ports: err out 1, one-cycle pulse on rejected bundle; word_count out 16, count of words delivered.

Function
REQ-009 SHALL encode DP_REG: cond|000|opcode|set_flags|rn|rd|low12; low12 = rs|0|shift|1|rm when use_rs, else shift_amount|shift|0|rm.
REQ-010 SHALL encode DP_IMM: cond|001|opcode|set_flags|rn|rd|rotate_imm|imm8.
REQ-011 SHALL encode LS_IMM: cond|010|P=1|U=1|B=0|W=0|load|rn|rd|imm12.
REQ-012 SHALL encode LS_REG: cond|011|1|1|0|0|load|rn|rd|shift_amount|shift|0|rm.
REQ-013 SHALL encode BRANCH: cond|101|link|offset24.
REQ-014 SHALL ignore inputs not used by the selected class.
REQ-015 SHALL treat cls in {100,110,111} or cond=1111 as illegal: bundle accepted (consumed), no word enqueued, err high exactly the cycle after acceptance.
REQ-016 SHALL buffer encoded words in a 2-entry FIFO; in_ready = (occupancy < 2), derived from registered state only, no combinational path from out_ready or in_valid.
REQ-017 SHALL present out_valid = (occupancy > 0), out_instr = head entry; out_instr held stable while out_valid high and out_ready low.
REQ-018 Latency: legal bundle accepted at edge N into empty FIFO SHALL give out_valid high after edge N, i.e. visible in cycle N+1.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged, preserve order; at occupancy 2 no push occurs (in_ready low) even if out_ready high.
REQ-020 Words SHALL leave in acceptance order; none dropped or duplicated.
REQ-021 word_count SHALL increment by 1 per output transfer, wrap 16'hFFFF -> 0; illegal bundles not counted.

Reset
REQ-022 On rst high (any time, asynchronously): occupancy 0, out_valid 0, out_instr 0, err 0, word_count 0; in_ready SHALL read 1 from the first cycle after rst deasserts.
REQ-023 Reset mid-operation SHALL discard all buffered words; no word issued before rst appears after it.

Structure
REQ-024 Shared package isa_pkg SHALL hold class codes (same values as the decoder's), condition codes incl. AL=1110 and NV=1111, and field bit positions.
REQ-025 Encoding SHALL be a pure function per class inside instr_encoder; the FIFO SHALL be sub-module instr_fifo2 (2-entry, 32-bit, async active-high reset).

Verification
REQ-026 DP_REG ADD: cls=000 cond=1110 opcode=0100 S=0 rn=2 rd=1 rm=3 shift=0 amt=0 use_rs=0 -> out_instr 0xE0821003 next cycle, word_count 1 after transfer.
REQ-027 DP_IMM MOV: cls=001 cond=1110 opcode=1101 rn=0 rd=0 rot=0 imm8=0xFF -> 0xE3A000FF; LS_IMM LDR cls=010 load=1 rn=1 rd=0 imm12=4 -> 0xE5910004.
REQ-028 BRANCH BL: cls=101 cond=1110 link=1 offset24=0x000010 -> 0xEB000010.
REQ-029 Backpressure: out_ready=0, offer 3 legal bundles back-to-back -> in_ready low after 2nd accept, 3rd held; release out_ready -> 3 words in order, word_count 3.
REQ-030 Illegal: cls=111 (and separately cond=1111) -> accepted, err one-cycle pulse, out_valid stays 0, word_count unchanged.
REQ-031 Reset: 2 words buffered, rst pulse mid-cycle -> out_valid 0 immediately, word_count 0, in_ready 1 after release, no stale word emitted.
